vc_input_buffer: RTL
====================

# vc_input_buffer

Multi-channel router input port. Accepts flits over a four-phase req/ack link, steers each flit into one of `NUM_VC` per-channel FIFOs by the VC field of the flit, and presents one head flit at a time to the crossbar arbiter over a req/grant link. Channels are served round-robin, and the routing address of the presented flit is exported. It is the generalised successor of the single-FIFO input path, with arbitrary width, depth and channel count.

## Interface
Parameters:
- `DATA_WIDTH`, 18: flit width; bits `[DATA_WIDTH-1 -: VC_W]` carry the VC id.
- `ADDRESS_SIZE`, 4: width of the routing address, taken from flit bits `[ADDRESS_SIZE-1:0]`.
- `NUM_VC`, 2: number of virtual channels, ≥1. `VC_W = max(1, $clog2(NUM_VC))`.
- `DEPTH`, 4: entries per channel FIFO, power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_data`, in, `DATA_WIDTH`: inbound flit; stable while `in_req`=1.
- `in_req`, in, 1: inbound request.
- `in_ack`, out, 1: inbound acknowledge.
- `out_data`, out, `DATA_WIDTH`: head flit of the selected channel.
- `out_vc`, out, `VC_W`: index of the selected channel.
- `pkt_address`, out, `ADDRESS_SIZE`: `out_data[ADDRESS_SIZE-1:0]`.
- `out_req`, out, 1: a flit is presented.
- `out_grant`, in, 1: downstream consumes the presented flit in this cycle.
- `vc_full`, out, `NUM_VC`: per-channel full flags.

## Operation
- Input handshake has two states, IDLE and ACKED.
  - IDLE: on an edge where `in_req`=1 and the target channel is not full, write `in_data` into that channel and go to ACKED. `in_ack`=1 from the next cycle.
  - If the target channel is full, stay in IDLE with `in_ack`=0 until space appears.
  - ACKED: hold `in_ack`=1 while `in_req`=1. On the first edge that sees `in_req`=0, return to IDLE; `in_ack`=0 from the next cycle.
  - A new flit is accepted only from IDLE, so there is exactly one write per four-phase cycle.
- A VC id ≥ `NUM_VC` is still acknowledged, but the flit is dropped and not written.
- Output selection:
  - `sel` is the first non-empty channel at or after `rr_ptr`, searching modulo `NUM_VC`.
  - `out_req` = any channel non-empty.
  - Once `out_req` rises, `sel` is frozen until a grant, so data does not switch under a pending request.
- On an edge with `out_req`=1 and `out_grant`=1: pop the head of `sel`, and set `rr_ptr` = `sel`+1 mod `NUM_VC`.
- A grant while `out_req`=0 is ignored.
- When `out_req`=0, `out_data`, `out_vc` and `pkt_address` are driven to 0.
- Each FIFO has separate read and write pointers of `$clog2(DEPTH)` bits that wrap naturally, plus a count of `$clog2(DEPTH)+1` bits.
  - full = (count == `DEPTH`); empty = (count == 0).
- A simultaneous write and pop on the same channel both occur and leave the count unchanged.
- Full is evaluated on the registered count, so a full channel does not accept a write in the same cycle as its pop.

## Timing
- Reset (asynchronous, in any state): `in_ack`=0, `out_req`=0, `out_data`/`out_vc`/`pkt_address`=0, `vc_full`=0, handshake state IDLE, all pointers, counts and `rr_ptr` = 0.
  - Memory contents are not reset.
  - A flit whose handshake is interrupted by reset is lost; the sender must restart.
- Write latency: `in_ack` rises one cycle after the accepting edge.
- Write-to-output latency:
  - A flit written at edge t into an empty buffer gives `out_req`=1 after edge t.
  - `out_data` is read combinationally from `mem[rd_ptr]`.
- Pop takes effect at the grant edge. The next head or channel is visible in the following cycle, which allows back-to-back grants.
- `vc_full` is registered-count derived and has no combinational path from the inputs.

## Configuration
- `VC_BUF_BYPASS_EN` defined: when all channels are empty, the handshake is in IDLE and `in_req`=1:
  - `in_data` is presented combinationally on `out_data`/`out_vc` with `out_req`=1.
  - A grant in that cycle acknowledges the flit without writing any FIFO.
  - The flit is written normally if no grant arrives.
- Undefined: no bypass; minimum input-to-output latency is one cycle.

## Structure
- `noc_pkg` holds the default width constants (`DATA_WIDTH`=18, `ADDRESS_SIZE`=4), the `hs_state_t` enum (IDLE, ACKED) and a `vc_w(n)` function.
- One sub-module, `vc_fifo`: a parametrised single-channel FIFO with `wr_en`, `rd_en`, `wr_data`, `rd_data`, `full`, `empty`, instantiated `NUM_VC` times in a generate loop.
- Arbitration and the handshake FSM live in the top level.

## Test plan
- Reset then idle: all outputs 0. Send flit 0x00005 on VC0 → `in_ack` high one cycle after `in_req`, then `out_req`=1, `out_vc`=0, `pkt_address`=5.
- Fill VC1 with 4 flits and no grant → `vc_full`[1]=1. A fifth VC1 flit is not acked. Grant once → fifth flit acked within 2 cycles.
- VC0 and VC1 each hold 3 flits; grant every cycle → `out_vc` sequence 0,1,0,1,0,1, then `out_req`=0.
- `out_req`=1 with no grant while a flit arrives on another VC → `out_vc`/`out_data` unchanged until the grant.
- Assert `rst_n`=0 in ACKED with 2 flits buffered → `in_ack`/`out_req` drop immediately. After release, a new handshake works.
- `VC_BUF_BYPASS_EN` defined, empty buffer, `in_req` with `out_grant`=1 in the same cycle → `out_data`=`in_data` in that cycle and the FIFO count stays 0.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared constants, handshake state type and VC-width helper for the router input path.
//   DATA_WIDTH   default flit width
//   ADDRESS_SIZE default routing address width
//   hs_state_t   four-phase input handshake states
//   vc_w(n)      width of a VC index for n channels (at least 1 bit)
package noc_pkg;

    localparam int DATA_WIDTH   = 18;
    localparam int ADDRESS_SIZE = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } hs_state_t;

    function automatic int vc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: single-channel FIFO with registered count; full/empty derive from the count only.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (memory is not reset)
//   wr_en, wr_data    write request and data (ignored when full)
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry, read combinationally
//   full, empty       count == DEPTH / count == 0
module vc_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: router input port steering four-phase flits into per-VC FIFOs, round-robin presentation to the crossbar.
// Optional feature: define VC_BUF_BYPASS_EN to present an inbound flit straight to the output when all FIFOs are empty.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_data        inbound flit, VC id in the top VC_W bits
//   in_req/in_ack  four-phase inbound handshake
//   out_data       presented head flit (0 when nothing presented)
//   out_vc         channel of the presented flit
//   pkt_address    out_data[ADDRESS_SIZE-1:0]
//   out_req        a flit is presented
//   out_grant      downstream consumes the presented flit this cycle
//   vc_full        per-channel full flags
module vc_input_buffer #(
    parameter int  DATA_WIDTH   = noc_pkg::DATA_WIDTH,
    parameter int  ADDRESS_SIZE = noc_pkg::ADDRESS_SIZE,
    parameter int  NUM_VC       = 2,
    parameter int  DEPTH        = 4,
    localparam int VC_W         = noc_pkg::vc_w(NUM_VC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_req,
    output logic                    in_ack,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [VC_W-1:0]         out_vc,
    output logic [ADDRESS_SIZE-1:0] pkt_address,
    output logic                    out_req,
    input  logic                    out_grant,
    output logic [NUM_VC-1:0]       vc_full
);

    import noc_pkg::*;

    hs_state_t             state;
    hs_state_t             state_nx;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [NUM_VC-1:0]     wr_en;
    logic [NUM_VC-1:0]     rd_en;
    logic [DATA_WIDTH-1:0] rd_data [NUM_VC];
    logic [VC_W-1:0]       tgt;
    logic [VC_W-1:0]       rr_ptr;
    logic [VC_W-1:0]       sel;
    logic [VC_W-1:0]       search;
    logic [VC_W-1:0]       lock_sel;
    logic                  valid_vc;
    logic                  accept;
    logic                  bypass;
    logic                  any;
    logic                  pop;
    logic                  locked;
    logic                  found;
    int                    idx;

    assign tgt      = in_data[DATA_WIDTH-1 -: VC_W];
    // zero-extend so the range check stays meaningful when NUM_VC is a power of two
    assign valid_vc = {1'b0, tgt} < (VC_W+1)'(NUM_VC);
    assign accept   = (state == IDLE) & in_req & ~(valid_vc & full[tgt]);
    assign in_ack   = state == ACKED;

`ifdef VC_BUF_BYPASS_EN
    assign bypass = (&empty) & (state == IDLE) & in_req & valid_vc;
`else
    assign bypass = 1'b0;
`endif

    assign any         = ~&empty;
    assign out_req     = any | bypass;
    assign pop         = out_req & out_grant;
    // a pending request keeps its channel until granted
    assign sel         = bypass ? tgt : (locked ? lock_sel : search);
    assign out_vc      = out_req ? sel : '0;
    assign out_data    = bypass ? in_data : (any ? rd_data[sel] : '0);
    assign pkt_address = out_data[ADDRESS_SIZE-1:0];
    assign vc_full     = full;

    always_comb begin
        state_nx = (state == IDLE) ? (accept ? ACKED : IDLE) : (in_req ? ACKED : IDLE);
    end

    always_comb begin
        found  = 1'b0;
        search = '0;
        idx    = 0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_VC;
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                search = VC_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_sel <= '0;
        end else begin
            state    <= state_nx;
            locked   <= out_req & ~out_grant;
            lock_sel <= sel;
            if (pop) rr_ptr <= VC_W'((int'(sel) + 1) % NUM_VC);
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        // a bypassed flit that is granted on arrival never enters the FIFO
        assign wr_en[v] = accept & valid_vc & ~(bypass & out_grant) & (tgt == VC_W'(v));
        assign rd_en[v] = pop & ~bypass & (sel == VC_W'(v));
        vc_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[v]),
            .rd_en   (rd_en[v]),
            .wr_data (in_data),
            .rd_data (rd_data[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

endmodule
